// File: rtl/tft_console_pkg.sv
// Shared types, control codes and sizing helpers for the TFT text console.
package tft_console_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_SCREEN = 2'd1,
    CLR_LINE   = 2'd2
  } state_t;

  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  // Bits needed to index 'cells' entries (at least one bit).
  function automatic int unsigned addr_width(input int unsigned cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/tft_fill_seq.sv
// Fill address sequencer: walks base..base+len-1, one address per cycle.
// The address/enable are combinational so the parent can register them
// alongside its own writes; done is registered and lines up with the
// parent's registered copy of the final address.
module tft_fill_seq #(
  parameter int unsigned AW           = 12,
  parameter bit          RESET_ACTIVE = 1'b1,
  parameter int unsigned RESET_LEN    = 2560
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          en_c,
  output logic [AW-1:0] addr_c,
  output logic          done
);

  logic          active;
  logic [AW-1:0] cnt;
  logic [AW-1:0] base_q;
  logic [AW-1:0] len_q;
  logic          last_c;

  assign en_c   = active;
  assign addr_c = base_q + cnt;
  assign last_c = active && (cnt == (len_q - AW'(1)));

  // Run counter; a reset can optionally launch a fill from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= RESET_ACTIVE;
      cnt    <= '0;
      base_q <= '0;
      len_q  <= AW'(RESET_LEN);
      done   <= 1'b0;
    end else begin
      done <= last_c;
      if (start) begin
        active <= 1'b1;
        cnt    <= '0;
        base_q <= base;
        len_q  <= len;
      end else if (active) begin
        if (last_c) begin
          active <= 1'b0;
        end else begin
          cnt <= cnt + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tft_console_ctrl.sv
// Terminal-style console: consumes a byte stream, tracks the cursor and is
// the sole writer of the TFT text memory (printing, backspace, line/screen
// clears). No scrolling: the cursor wraps from the last row back to row 0.
module tft_console_ctrl
  import tft_console_pkg::*;
#(
  parameter int unsigned COLS           = 80,
  parameter int unsigned ROWS           = 32,
  parameter logic [7:0]  FILL_CHAR      = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW            = addr_width(COLS * ROWS),
  localparam int unsigned XW            = addr_width(COLS),
  localparam int unsigned YW            = addr_width(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          char_valid,
  input  logic [7:0]    char_data,
  output logic          char_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          busy
);

  state_t        state;
  state_t        state_nxt;

  logic          accept_c;
  logic          is_print_c;
  logic          at_eol_c;
  logic [YW-1:0] y_inc_c;
  logic [AW-1:0] cur_addr_c;

  logic          char_wr_c;
  logic [AW-1:0] char_addr_c;
  logic [7:0]    char_dat_c;
  logic [XW-1:0] x_nxt_c;
  logic [YW-1:0] y_nxt_c;
  logic          fill_start_c;
  logic [AW-1:0] fill_base_c;
  logic [AW-1:0] fill_len_c;

  logic          fill_en_c;
  logic [AW-1:0] fill_addr_c;
  logic          fill_done;

  assign char_ready = (state == IDLE) && !reset;
  assign accept_c   = char_valid && char_ready;
  assign is_print_c = (char_data >= PRINT_MIN) && (char_data <= PRINT_MAX);
  assign at_eol_c   = (cursor_x == XW'(COLS - 1));
  assign y_inc_c    = (cursor_y == YW'(ROWS - 1)) ? '0 : cursor_y + YW'(1);
  assign cur_addr_c = AW'(cursor_y) * AW'(COLS) + AW'(cursor_x);

  tft_fill_seq #(
    .AW           (AW),
    .RESET_ACTIVE (CLEAR_ON_RESET),
    .RESET_LEN    (COLS * ROWS)
  ) u_fill (
    .clk    (clk),
    .reset  (reset),
    .start  (fill_start_c),
    .base   (fill_base_c),
    .len    (fill_len_c),
    .en_c   (fill_en_c),
    .addr_c (fill_addr_c),
    .done   (fill_done)
  );

  // State register; reset optionally lands in a full-screen clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLR_SCREEN : IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: line/screen clears are entered from accepted bytes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if ((is_print_c && at_eol_c) || (char_data == CH_LF)) begin
            state_nxt = CLR_LINE;
          end else if (char_data == CH_FF) begin
            state_nxt = CLR_SCREEN;
          end
        end
      end
      CLR_SCREEN, CLR_LINE: begin
        if (fill_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte interpretation: cursor update, direct write and fill launch.
  always_comb begin
    char_wr_c    = 1'b0;
    char_addr_c  = cur_addr_c;
    char_dat_c   = char_data;
    x_nxt_c      = cursor_x;
    y_nxt_c      = cursor_y;
    fill_start_c = 1'b0;
    fill_base_c  = '0;
    fill_len_c   = AW'(COLS * ROWS);
    if ((state == IDLE) && accept_c) begin
      if (is_print_c) begin
        char_wr_c = 1'b1;
        if (at_eol_c) begin
          x_nxt_c      = '0;
          y_nxt_c      = y_inc_c;
          fill_start_c = 1'b1;
          fill_base_c  = AW'(y_inc_c) * AW'(COLS);
          fill_len_c   = AW'(COLS);
        end else begin
          x_nxt_c = cursor_x + XW'(1);
        end
      end else if (char_data == CH_LF) begin
        x_nxt_c      = '0;
        y_nxt_c      = y_inc_c;
        fill_start_c = 1'b1;
        fill_base_c  = AW'(y_inc_c) * AW'(COLS);
        fill_len_c   = AW'(COLS);
      end else if (char_data == CH_CR) begin
        x_nxt_c = '0;
      end else if (char_data == CH_BS) begin
        if (cursor_x != '0) begin
          x_nxt_c     = cursor_x - XW'(1);
          char_wr_c   = 1'b1;
          char_addr_c = cur_addr_c - AW'(1);
          char_dat_c  = FILL_CHAR;
        end
      end else if (char_data == CH_FF) begin
        x_nxt_c      = '0;
        y_nxt_c      = '0;
        fill_start_c = 1'b1;
      end
    end
  end

  // Registered write port, cursor and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      busy     <= CLEAR_ON_RESET;
    end else begin
      wr_en <= fill_en_c || char_wr_c;
      if (fill_en_c) begin
        wr_addr <= fill_addr_c;
        wr_data <= FILL_CHAR;
      end else if (char_wr_c) begin
        wr_addr <= char_addr_c;
        wr_data <= char_dat_c;
      end
      cursor_x <= x_nxt_c;
      cursor_y <= y_nxt_c;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_tft_console_ctrl.sv
// Bench for tft_console_ctrl: directed scenarios plus a random byte stream,
// checked against a screen/cursor model kept in the bench.
`timescale 1ns/1ps
module tb_tft_console_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 32;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  always #4 clk = ~clk;

  tft_console_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] dut_scr [CELLS];
  logic [7:0] mdl_scr [CELLS];
  int         mx;
  int         my;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge clk) cyc++;

  // Record every write the DUT issues, with the cycle it was visible in.
  always @(negedge clk) begin
    if (!reset && wr_en === 1'b1) begin
      got_q.push_back('{int'(wr_addr), int'(wr_data), cyc});
      if (int'(wr_addr) < CELLS) dut_scr[wr_addr] = wr_data;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void m_put(input int a, input int d);
    logic [7:0] b;
    b = d[7:0];
    mdl_scr[a] = b;
    exp_q.push_back('{a, d, 0});
  endfunction

  function automatic void m_fill(input int base, input int len);
    for (int i = 0; i < len; i++) m_put(base + i, 32'h20);
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_put(my * COLS + mx, int'(b));
      if (mx < COLS - 1) mx++;
      else begin
        mx = 0;
        my = (my + 1) % ROWS;
        m_fill(my * COLS, COLS);
      end
    end else if (b == 8'h0A) begin
      mx = 0;
      my = (my + 1) % ROWS;
      m_fill(my * COLS, COLS);
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h08) begin
      if (mx > 0) begin
        mx--;
        m_put(my * COLS + mx, 32'h20);
      end
    end else if (b == 8'h0C) begin
      mx = 0;
      my = 0;
      m_fill(0, CELLS);
    end
  endfunction

  function automatic wr_t got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '{-1, -1, -1};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (char_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (char_ready !== 1'b1) check({tag, "_ready_timeout"}, 32'(char_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    char_valid = 1'b1;
    char_data  = b;
    wait_ready("send");
    m_byte(b);
    @(negedge clk);
    char_valid = 1'b0;
    check("cursor_x", 32'(cursor_x), mx);
    check("cursor_y", 32'(cursor_y), my);
  endtask

  task automatic settle(input string tag);
    wait_ready(tag);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_q(input string tag);
    int errs = 0;
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({tag, "_wr_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++)
      if (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data) errs++;
    check({tag, "_wr_seq_errs"}, errs, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32'h20, 32'h7E));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int overlap;
    int busy_err;
    int ready_cyc;
    int diffs;
    int r;
    logic [7:0] b;

    reset      = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    mx = 0;
    my = 0;
    for (int i = 0; i < CELLS; i++) begin
      dut_scr[i] = 8'h00;
      mdl_scr[i] = 8'h00;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_cursor_x", 32'(cursor_x), 0);
    check("rst_cursor_y", 32'(cursor_y), 0);
    check("rst_char_ready", 32'(char_ready), 0);

    // Power-on clear
    m_fill(0, CELLS);
    reset = 1'b0;
    n = 0; overlap = 0; busy_err = 0;
    while (char_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
      if (wr_en === 1'b1 && char_ready === 1'b1) overlap++;
      if (busy !== !char_ready) busy_err++;
    end
    ready_cyc = cyc;
    check("por_ready_seen", 32'(char_ready), 1);
    check("por_ready_during_write", overlap, 0);
    check("por_busy_vs_ready", busy_err, 0);
    repeat (2) @(negedge clk);
    check("por_last_addr", got_at(got_q.size() - 1).addr, CELLS - 1);
    check("por_ready_after_last", ready_cyc - got_at(got_q.size() - 1).cyc, 1);
    check("por_cursor_x", 32'(cursor_x), 0);
    check("por_cursor_y", 32'(cursor_y), 0);
    compare_q("por");

    // "AB" back-to-back
    send(8'h41);
    send(8'h42);
    check("ab_ready", 32'(char_ready), 1);
    settle("ab");
    check("ab_w0_addr", got_at(0).addr, 0);
    check("ab_w0_data", got_at(0).data, 32'h41);
    check("ab_w1_addr", got_at(1).addr, 1);
    check("ab_w1_data", got_at(1).data, 32'h42);
    check("ab_consecutive", got_at(1).cyc - got_at(0).cyc, 1);
    compare_q("ab");

    // Wrap at end of row 5
    send(8'h0C);
    settle("z_ff");
    for (int i = 0; i < 5; i++) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send(rand_print());
    settle("z_setup");
    compare_q("z_setup");
    send(8'h5A);
    settle("z");
    check("z_count", got_q.size(), 81);
    check("z_char_addr", got_at(0).addr, 479);
    check("z_char_data", got_at(0).data, 32'h5A);
    check("z_fill_first", got_at(1).addr, 480);
    check("z_fill_last", got_at(80).addr, 559);
    check("z_fill_span", got_at(80).cyc - got_at(0).cyc, 80);
    check("z_cursor_x", 32'(cursor_x), 0);
    check("z_cursor_y", 32'(cursor_y), 6);
    compare_q("z");

    // LF from the last row wraps to row 0; byte held during the fill
    for (int i = 0; i < 25; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(rand_print());
    settle("lf_setup");
    compare_q("lf_setup");
    send(8'h0A);
    send(8'h51);
    settle("lf");
    check("lf_count", got_q.size(), 81);
    check("lf_fill_first", got_at(0).addr, 0);
    check("lf_fill_last", got_at(79).addr, 79);
    check("lf_held_addr", got_at(80).addr, 0);
    check("lf_held_data", got_at(80).data, 32'h51);
    check("lf_held_after_fill", got_at(80).cyc - got_at(79).cyc, 2);
    compare_q("lf");

    // Backspace
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 3; i++) send(rand_print());
    settle("bs_setup");
    compare_q("bs_setup");
    send(8'h08);
    settle("bs1");
    check("bs1_count", got_q.size(), 1);
    check("bs1_addr", got_at(0).addr, 162);
    check("bs1_data", got_at(0).data, 32'h20);
    check("bs1_cursor_x", 32'(cursor_x), 2);
    compare_q("bs1");
    send(8'h0D);
    send(8'h08);
    settle("bs0");
    check("bs0_count", got_q.size(), 0);
    check("bs0_cursor_x", 32'(cursor_x), 0);
    check("bs0_cursor_y", 32'(cursor_y), 2);
    compare_q("bs0");

    // Reset in the middle of a line clear (row 3, fill index 40)
    send(8'h0A);
    repeat (41) @(negedge clk);
    check("mid_wr_en", 32'(wr_en), 1);
    check("mid_wr_addr", 32'(wr_addr), 3 * COLS + 40);
    reset = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_cursor_x", 32'(cursor_x), 0);
    check("mid_rst_cursor_y", 32'(cursor_y), 0);
    got_q.delete();
    exp_q.delete();
    mx = 0;
    my = 0;
    m_fill(0, CELLS);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    settle("mid");
    check("mid_restart_addr", got_at(0).addr, 0);
    compare_q("mid");

    // Random byte stream
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = rand_print();
      else if (r < 78) b = 8'h0A;
      else if (r < 84) b = 8'h0D;
      else if (r < 92) b = 8'h08;
      else if (r < 94) b = 8'h0C;
      else if (r < 96) b = 8'h7F;
      else             b = 8'($urandom_range(128, 255));
      send(b);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (k % 50 == 49) begin
        settle("rnd");
        compare_q("rnd");
      end
    end
    settle("rnd_end");
    compare_q("rnd_end");
    diffs = 0;
    for (int i = 0; i < CELLS; i++) if (dut_scr[i] !== mdl_scr[i]) diffs++;
    check("screen_diff_cells", diffs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tft_console_ctrl.md
Name: tft_console_ctrl

Overview:
- Terminal-style text console controller that drives the TFT controller's write-only text-memory port.
- Accepts a byte stream from the CPU MMIO path over a valid/ready handshake and tracks the cursor.
- Interprets control characters and sequences multi-cycle fills (clear screen, clear line) into the 80x32 character buffer.
- Sits between the CPU peripheral bus and the TFT text write port; it is the sole writer of text memory.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 32, text rows.
- FILL_CHAR, 8'h20, byte written by clear operations and by backspace.
- CLEAR_ON_RESET, 1, when 1 a full-screen clear runs automatically after reset.

Ports:
- clk  input  1  system clock, 125 MHz.
- reset  input  1  asynchronous, active-high reset.
- char_valid  input  1  producer has a byte on char_data.
- char_data  input  8  byte to print or interpret.
- char_ready  output  1  controller accepts char_data this cycle.
- wr_en  output  1  write strobe to TFT text memory (write_en).
- wr_addr  output  12  text-memory cell index, row*COLS+col.
- wr_data  output  8  byte to write.
- cursor_x  output  7  current column, 0..COLS-1.
- cursor_y  output  5  current row, 0..ROWS-1.
- busy  output  1  fill operation in progress.

Behaviour:
- Interface clock and reset: reset is asynchronous and active-high; the clock is clk.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, cursor_x=0, cursor_y=0.
  - State is CLR_SCREEN if CLEAR_ON_RESET=1, otherwise IDLE.
  - char_ready=0 while reset is asserted.
- States:
  - IDLE: char_ready=1; accepts bytes.
  - CLR_SCREEN: fill counter runs 0..COLS*ROWS-1.
  - CLR_LINE: fill counter runs 0..COLS-1 over row cursor_y.
- Handshake:
  - A transfer occurs when char_valid && char_ready.
  - char_ready = (state==IDLE), combinational from the state register.
  - Back-to-back accepts are allowed, one byte per cycle.
- Write latency: all wr_* outputs are registered. A write caused by a byte accepted in cycle N appears with wr_en=1 in cycle N+1, for exactly one cycle.
- Printable byte (0x20..0x7E):
  - Write the byte at (cursor_x, cursor_y).
  - If cursor_x<COLS-1, then cursor_x+1.
  - If cursor_x=COLS-1, then cursor_x=0, cursor_y=(cursor_y+1) mod ROWS, and enter CLR_LINE for the new row.
- 0x0A (LF): cursor_x=0, cursor_y=(cursor_y+1) mod ROWS, enter CLR_LINE. Row 31 wraps to row 0; there is no scrolling.
- 0x0D (CR): cursor_x=0, no write.
- 0x08 (BS):
  - If cursor_x>0: cursor_x-1, then write FILL_CHAR at the new position.
  - If cursor_x=0: no-op. Backspace never crosses rows.
- 0x0C (FF): cursor to (0,0), enter CLR_SCREEN.
- Any other byte: consumed and ignored; no write, cursor unchanged.
- CLR_SCREEN:
  - Issues wr_en=1 with wr_data=FILL_CHAR, wr_addr=0..2559, on consecutive cycles.
  - Returns to IDLE the cycle after the last write. busy=1 throughout.
  - Takes COLS*ROWS cycles.
- CLR_LINE:
  - Issues wr_addr=cursor_y*COLS+0..COLS-1, one per cycle (COLS cycles), then IDLE.
  - Cursor stays at (0, new row).
- cursor_x/cursor_y update in the cycle after acceptance, together with the write.
- Address arithmetic is 12-bit unsigned; the maximum is 2559, so no overflow.
- Reset mid-fill aborts immediately: wr_en drops asynchronously, the cursor returns to (0,0), and a new full clear starts if CLEAR_ON_RESET=1.
- char_valid asserted during a fill is held off by char_ready=0. The byte must be held stable by the producer, and no byte is lost.

Decomposition:
- Package tft_console_pkg holds:
  - state enum state_t {IDLE, CLR_SCREEN, CLR_LINE}.
  - Constants CH_LF=8'h0A, CH_CR=8'h0D, CH_BS=8'h08, CH_FF=8'h0C, PRINT_MIN=8'h20, PRINT_MAX=8'h7E.
  - Address-width function.
- One sub-module, tft_fill_seq: given start, base address and length, emits consecutive addresses and pulses done. It is used by both clear states.

Test Plan:
- Reset with CLEAR_ON_RESET=1:
  - 2560 writes of 0x20, addresses 0..2559, char_ready=0.
  - char_ready rises the cycle after the write to address 2559; cursor at (0,0).
- Send "AB" back-to-back from (0,0):
  - wr (0,0x41), then wr (1,0x42) on consecutive cycles.
  - Cursor ends at (2,0); char_ready stays 1.
- Cursor at (79,5), send 'Z':
  - Write at address 479=0x5A.
  - Then 80 fills at addresses 480..559; cursor ends at (0,6).
- Cursor at (10,31), send 0x0A:
  - Cursor goes to (0,0), then fills at addresses 0..79.
  - A char_valid held during the fill is accepted only after the fill completes.
- Cursor at (3,2), send 0x08, then 0x08 with cursor at (0,2):
  - First: write at address 162=0x20, cursor (2,2).
  - Second: no write, cursor unchanged.
- Assert reset during CLR_LINE at fill index 40:
  - wr_en=0 immediately and cursor (0,0).
  - A full-screen clear restarts from address 0.
